// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C target: FSM states, ACK/NACK bus levels, default address.
package i2c_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_WRITE,
        ST_ACK_DATA,
        ST_READ,
        ST_READ_ACK,
        ST_WAIT_STOP
    } state_t;

    localparam logic       ACK          = 1'b0;
    localparam logic       NACK         = 1'b1;
    localparam logic [6:0] DEFAULT_ADDR = 7'h08;

endpackage

// File: rtl/i2c_slave_if.sv
// Core-side byte interface of the I2C target: received bytes out, bytes to transmit in.
interface i2c_slave_if;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       rw;
    logic       busy;

    modport slave  (input tx_data, output rx_data, rx_valid, tx_req, rw, busy);
    modport master (output tx_data, input rx_data, rx_valid, tx_req, rw, busy);
endinterface

// File: rtl/i2c_slave_sync.sv
// Synchronizes SCL/SDA into clk and derives SCL edges plus START/STOP conditions.
// Edge outputs stay quiet until the pipeline has refilled after reset, so stale reset values never fake an edge.
module i2c_slave_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);
    logic [SYNC_STAGES-1:0] scl_pipe, sda_pipe;
    logic [SYNC_STAGES:0]   armed_pipe;
    logic                   scl_d, sda_d, scl, armed;

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_pipe   <= '1;
            sda_pipe   <= '1;
            scl_d      <= 1'b1;
            sda_d      <= 1'b1;
            armed_pipe <= '0;
        end else begin
            scl_pipe   <= {scl_pipe[SYNC_STAGES-2:0], scl_in};
            sda_pipe   <= {sda_pipe[SYNC_STAGES-2:0], sda_in};
            scl_d      <= scl_pipe[SYNC_STAGES-1];
            sda_d      <= sda_pipe[SYNC_STAGES-1];
            armed_pipe <= {armed_pipe[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign scl      = scl_pipe[SYNC_STAGES-1];
    assign sda      = sda_pipe[SYNC_STAGES-1];
    assign armed    = armed_pipe[SYNC_STAGES];
    assign scl_rise = armed &  scl & ~scl_d;
    assign scl_fall = armed & ~scl &  scl_d;
    assign start    = armed &  scl &  scl_d &  sda_d & ~sda;
    assign stop     = armed &  scl &  scl_d & ~sda_d &  sda;
endmodule

// File: rtl/i2c_slave.sv
// Oversampled 7-bit-address I2C target; SDA is open-drain (low or Z), SCL is never driven.
// Define GENERAL_CALL_EN to also ACK general-call writes (address 7'h00 with R/W=0).
module i2c_slave
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = DEFAULT_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    i2c_slave_if.slave core
);
    state_t     state, state_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic [7:0] rx_data, rx_data_nxt;
    logic       sda_low, sda_low_nxt;
    logic       rx_valid, rx_valid_nxt;
    logic       tx_req, tx_req_nxt;
    logic       rw, rw_nxt;
    logic       busy, busy_nxt;
    logic       reload, reload_nxt;
    logic       sda_s, scl_rise, scl_fall, start, stop;
    logic       addr_hit;

    i2c_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (i2c_scl),
        .sda_in   (i2c_sda),
        .sda      (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    // Evaluated on the 8th address rise: shreg holds the 7 address bits, sda_s is R/W.
    always_comb begin
        addr_hit = (shreg[6:0] == SLAVE_ADDR);
`ifdef GENERAL_CALL_EN
        if (shreg[6:0] == 7'h00 && sda_s == 1'b0)
            addr_hit = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
            rx_data  <= 8'h00;
            sda_low  <= 1'b0;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            rw       <= 1'b0;
            busy     <= 1'b0;
            reload   <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
            rx_data  <= rx_data_nxt;
            sda_low  <= sda_low_nxt;
            rx_valid <= rx_valid_nxt;
            tx_req   <= tx_req_nxt;
            rw       <= rw_nxt;
            busy     <= busy_nxt;
            reload   <= reload_nxt;
        end
    end

    // In the ACK states sda_low doubles as the phase flag: first fall drives ACK, second releases.
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        rx_data_nxt  = rx_data;
        sda_low_nxt  = sda_low;
        rx_valid_nxt = 1'b0;
        tx_req_nxt   = 1'b0;
        rw_nxt       = rw;
        busy_nxt     = busy;
        reload_nxt   = reload;
        if (stop) begin
            state_nxt   = ST_IDLE;
            sda_low_nxt = 1'b0;
            busy_nxt    = 1'b0;
            reload_nxt  = 1'b0;
        end else if (start) begin
            state_nxt   = ST_ADDR;
            bit_cnt_nxt = 3'd0;
            sda_low_nxt = 1'b0;
            reload_nxt  = 1'b0;
        end else begin
            case (state)
                ST_ADDR: if (scl_rise) begin
                    shreg_nxt   = {shreg[6:0], sda_s};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (addr_hit) begin
                            state_nxt = ST_ACK_ADDR;
                            rw_nxt    = sda_s;
                            busy_nxt  = 1'b1;
                        end else begin
                            state_nxt = ST_WAIT_STOP;
                            busy_nxt  = 1'b0;
                        end
                    end
                end
                ST_ACK_ADDR: if (scl_fall) begin
                    bit_cnt_nxt = 3'd0;
                    if (!sda_low) begin
                        sda_low_nxt = 1'b1;
                    end else if (rw) begin
                        tx_req_nxt  = 1'b1;
                        shreg_nxt   = core.tx_data;
                        sda_low_nxt = ~core.tx_data[7];
                        state_nxt   = ST_READ;
                    end else begin
                        sda_low_nxt = 1'b0;
                        state_nxt   = ST_WRITE;
                    end
                end
                ST_WRITE: if (scl_rise) begin
                    shreg_nxt   = {shreg[6:0], sda_s};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_data_nxt  = {shreg[6:0], sda_s};
                        rx_valid_nxt = 1'b1;
                        state_nxt    = ST_ACK_DATA;
                    end
                end
                ST_ACK_DATA: if (scl_fall) begin
                    sda_low_nxt = ~sda_low;
                    if (sda_low)
                        state_nxt = ST_WRITE;
                end
                ST_READ: begin
                    if (scl_rise)
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    if (scl_fall) begin
                        if (bit_cnt == 3'd0) begin
                            sda_low_nxt = 1'b0;
                            state_nxt   = ST_READ_ACK;
                        end else begin
                            shreg_nxt   = {shreg[6:0], 1'b0};
                            sda_low_nxt = ~shreg[6];
                        end
                    end
                end
                ST_READ_ACK: begin
                    if (scl_rise) begin
                        if (sda_s == NACK) begin
                            state_nxt = ST_WAIT_STOP;
                        end else begin
                            tx_req_nxt = 1'b1;
                            shreg_nxt  = core.tx_data;
                            reload_nxt = 1'b1;
                        end
                    end else if (scl_fall && reload) begin
                        sda_low_nxt = ~shreg[7];
                        reload_nxt  = 1'b0;
                        bit_cnt_nxt = 3'd0;
                        state_nxt   = ST_READ;
                    end
                end
                default: ;
            endcase
        end
    end

    assign i2c_sda       = sda_low ? ACK : 1'bz;
    assign core.rx_data  = rx_data;
    assign core.rx_valid = rx_valid;
    assign core.tx_req   = tx_req;
    assign core.rw       = rw;
    assign core.busy     = busy;
endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged I2C master with a pull-up, checks by immediate assertions.
module tb_i2c_slave;
    logic       clk = 1'b0;
    logic       reset;
    logic       i2c_scl;
    logic       m_sda_low;
    wire        i2c_sda;
    int         tests = 0;
    int         fails = 0;
    int         rx_hi = 0;
    int         tx_hi = 0;
    logic [7:0] rx_last = 8'h00;

    i2c_slave_if core_if ();

    pullup (i2c_sda);
    assign i2c_sda = m_sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave #(.SLAVE_ADDR(7'h08), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .i2c_scl (i2c_scl),
        .i2c_sda (i2c_sda),
        .core    (core_if)
    );

    // Pulse monitor: counts high cycles so a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (core_if.rx_valid) begin
            rx_hi   = rx_hi + 1;
            rx_last = core_if.rx_data;
        end
        if (core_if.tx_req)
            tx_hi = tx_hi + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_q();
        repeat (4) @(negedge clk);
    endtask

    task automatic clk_bit(input logic b, output logic r);
        m_sda_low = ~b;
        wait_q();
        i2c_scl = 1'b1;
        wait_q();
        r = i2c_sda;
        wait_q();
        i2c_scl = 1'b0;
        wait_q();
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0;
        wait_q();
        i2c_scl = 1'b1;
        wait_q();
        m_sda_low = 1'b1;
        wait_q();
        i2c_scl = 1'b0;
        wait_q();
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1;
        wait_q();
        i2c_scl = 1'b1;
        wait_q();
        m_sda_low = 1'b0;
        wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--)
            clk_bit(b[i], r);
        clk_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, input logic [7:0] next_tx, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, r);
            d[i] = r;
        end
        core_if.tx_data = next_tx;
        clk_bit(mack, r);
    endtask

    initial begin
        logic       ack;
        logic       r;
        logic [7:0] d;
        int         rx0, tx0;

        reset           = 1'b1;
        i2c_scl         = 1'b1;
        m_sda_low       = 1'b0;
        core_if.tx_data = 8'h00;
        repeat (5) @(negedge clk);
        check("rst_rx_data", core_if.rx_data, 8'h00);
        check("rst_rx_valid", core_if.rx_valid, 1'b0);
        check("rst_tx_req", core_if.tx_req, 1'b0);
        check("rst_rw", core_if.rw, 1'b0);
        check("rst_busy", core_if.busy, 1'b0);
        check("rst_sda", i2c_sda, 1'b1);
        reset = 1'b0;
        repeat (8) @(negedge clk);

        // Write 0x08+W, 0xEE
        rx0 = rx_hi;
        i2c_start();
        send_byte(8'h10, ack);
        check("w_addr_ack", ack, 1'b0);
        check("w_busy", core_if.busy, 1'b1);
        check("w_rw", core_if.rw, 1'b0);
        send_byte(8'hEE, ack);
        check("w_data_ack", ack, 1'b0);
        check("w_rx_last", rx_last, 8'hEE);
        check("w_rx_data", core_if.rx_data, 8'hEE);
        check("w_rx_pulses", rx_hi - rx0, 1);
        check("w_busy_hold", core_if.busy, 1'b1);
        i2c_stop();
        check("w_busy_stop", core_if.busy, 1'b0);

        // Wrong address 0x09+W: NACK, data ignored
        rx0 = rx_hi;
        i2c_start();
        send_byte(8'h12, ack);
        check("nack_addr", ack, 1'b1);
        check("nack_busy", core_if.busy, 1'b0);
        send_byte(8'h55, ack);
        check("nack_data", ack, 1'b1);
        check("nack_rx_pulses", rx_hi - rx0, 0);
        check("nack_rx_data", core_if.rx_data, 8'hEE);
        i2c_stop();

        // Read 0x08+R, tx_data 0xA5, master NACKs
        core_if.tx_data = 8'hA5;
        tx0 = tx_hi;
        i2c_start();
        send_byte(8'h11, ack);
        check("r_addr_ack", ack, 1'b0);
        check("r_rw", core_if.rw, 1'b1);
        check("r_busy", core_if.busy, 1'b1);
        read_byte(1'b1, 8'h00, d);
        check("r_data", d, 8'hA5);
        check("r_tx_pulses", tx_hi - tx0, 1);
        read_byte(1'b1, 8'h00, d);
        check("r_wait_stop_idle_bus", d, 8'hFF);
        check("r_wait_stop_no_req", tx_hi - tx0, 1);
        i2c_stop();
        check("r_busy_stop", core_if.busy, 1'b0);

        // Multi-byte write 0x11, 0x22
        rx0 = rx_hi;
        i2c_start();
        send_byte(8'h10, ack);
        check("mw_addr_ack", ack, 1'b0);
        send_byte(8'h11, ack);
        check("mw_ack1", ack, 1'b0);
        check("mw_rx1", rx_last, 8'h11);
        send_byte(8'h22, ack);
        check("mw_ack2", ack, 1'b0);
        check("mw_rx2", core_if.rx_data, 8'h22);
        check("mw_rx_pulses", rx_hi - rx0, 2);
        i2c_stop();

        // Repeated START: 0x08+W then 0x08+R, two read bytes (ACK then NACK)
        core_if.tx_data = 8'h3C;
        tx0 = tx_hi;
        i2c_start();
        send_byte(8'h10, ack);
        check("rs_w_ack", ack, 1'b0);
        i2c_start();
        check("rs_busy_kept", core_if.busy, 1'b1);
        send_byte(8'h11, ack);
        check("rs_r_ack", ack, 1'b0);
        check("rs_rw", core_if.rw, 1'b1);
        check("rs_busy", core_if.busy, 1'b1);
        read_byte(1'b0, 8'hC3, d);
        check("rs_data1", d, 8'h3C);
        read_byte(1'b1, 8'h00, d);
        check("rs_data2", d, 8'hC3);
        check("rs_tx_pulses", tx_hi - tx0, 2);
        i2c_stop();

        // Reset in the middle of a data byte, then a fresh transfer
        i2c_start();
        send_byte(8'h10, ack);
        check("mr_addr_ack", ack, 1'b0);
        clk_bit(1'b1, r);
        clk_bit(1'b1, r);
        clk_bit(1'b1, r);
        check("mr_busy_before", core_if.busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("mr_busy", core_if.busy, 1'b0);
        check("mr_rx_data", core_if.rx_data, 8'h00);
        check("mr_rx_valid", core_if.rx_valid, 1'b0);
        check("mr_tx_req", core_if.tx_req, 1'b0);
        check("mr_sda", i2c_sda, 1'b1);
        reset = 1'b0;
        wait_q();
        i2c_stop();
        rx0 = rx_hi;
        i2c_start();
        send_byte(8'h10, ack);
        check("mr_new_addr_ack", ack, 1'b0);
        send_byte(8'h5A, ack);
        check("mr_new_data_ack", ack, 1'b0);
        check("mr_new_rx", core_if.rx_data, 8'h5A);
        check("mr_new_pulses", rx_hi - rx0, 1);
        i2c_stop();
        check("mr_new_busy_stop", core_if.busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
